// File: rtl/comparator_2bit_if.sv
// rtl/comparator_2bit_if.sv - sample/result bundle for the registered magnitude comparator
interface comparator_2bit_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             A_gt_B;
    logic             A_eq_B;
    logic             A_lt_B;
    logic             out_valid;

    modport master (
        output in_valid,
        output signed_mode,
        output A,
        output B,
        input  A_gt_B,
        input  A_eq_B,
        input  A_lt_B,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  signed_mode,
        input  A,
        input  B,
        output A_gt_B,
        output A_eq_B,
        output A_lt_B,
        output out_valid
    );
endinterface

// File: rtl/comparator_2bit.sv
// rtl/comparator_2bit.sv - registered one-hot magnitude comparator, unsigned or two's-complement per sample
module comparator_2bit #(
    parameter int WIDTH = 2
) (
    input logic                clk,
    input logic                rst_n,
    comparator_2bit_if.slave   bus
);
    logic [WIDTH-1:0] sign_flip;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             gt_next;
    logic             eq_next;
    logic             lt_next;

    logic             gt_q;
    logic             eq_q;
    logic             lt_q;
    logic             valid_q;

    // Inverting the MSB maps two's-complement order onto unsigned order.
    always_comb begin
        sign_flip            = '0;
        sign_flip[WIDTH-1]   = bus.signed_mode;
    end

    assign a_key   = bus.A ^ sign_flip;
    assign b_key   = bus.B ^ sign_flip;
    assign eq_next = (bus.A == bus.B);
    assign gt_next = (a_key > b_key);
    assign lt_next = !eq_next && !gt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                gt_q <= gt_next;
                eq_q <= eq_next;
                lt_q <= lt_next;
            end
        end
    end

    assign bus.A_gt_B    = gt_q;
    assign bus.A_eq_B    = eq_q;
    assign bus.A_lt_B    = lt_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_comparator_2bit.sv
// tb/tb_comparator_2bit.sv - scoreboard bench for comparator_2bit at WIDTH=2 and WIDTH=4
module tb_comparator_2bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comparator_2bit_if #(.WIDTH(2)) b2 ();
    comparator_2bit_if #(.WIDTH(4)) b4 ();

    comparator_2bit #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    comparator_2bit #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    typedef struct {
        int         due;
        logic [2:0] flags;
    } exp_t;

    exp_t       q [2][$];
    exp_t       e;
    logic [3:0] act [2];
    logic [2:0] held [2];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got {valid,gt,eq,lt}=%b, expected %b", name, cyc, got, exp);
        end
    endtask

    // Reference: interpret bit patterns as integers and compare arithmetically.
    function automatic logic [2:0] ref_cmp(input int w, input int a, input int b, input bit sm);
        int av = a;
        int bv = b;
        if (sm && a >= (1 << (w - 1))) av = a - (1 << w);
        if (sm && b >= (1 << (w - 1))) bv = b - (1 << w);
        if (av > bv) return 3'b100;
        if (av == bv) return 3'b010;
        return 3'b001;
    endfunction

    task automatic drive(input int a2, input int bb2, input bit s2, input bit v2,
                         input int a4, input int bb4, input bit s4, input bit v4);
        logic [1:0] x2, y2;
        logic [3:0] x4, y4;
        @(posedge clk);
        #1;
        x2 = a2[1:0]; y2 = bb2[1:0];
        x4 = a4[3:0]; y4 = bb4[3:0];
        b2.A = x2; b2.B = y2; b2.signed_mode = s2; b2.in_valid = v2;
        b4.A = x4; b4.B = y4; b4.signed_mode = s4; b4.in_valid = v4;
        if (v2) q[0].push_back('{cyc + 1, ref_cmp(2, int'(x2), int'(y2), s2)});
        if (v4) q[1].push_back('{cyc + 1, ref_cmp(4, int'(x4), int'(y4), s4)});
    endtask

    task automatic d2(input int a, input int b, input bit s, input bit v);
        drive(a, b, s, v, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic d4(input int a, input int b, input bit s, input bit v);
        drive(0, 0, 1'b0, 1'b0, a, b, s, v);
    endtask

    always @(negedge clk) begin
        act[0] = {b2.out_valid, b2.A_gt_B, b2.A_eq_B, b2.A_lt_B};
        act[1] = {b4.out_valid, b4.A_gt_B, b4.A_eq_B, b4.A_lt_B};
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                held[d] = 3'b000;
                check(d == 0 ? "w2_in_reset" : "w4_in_reset", act[d], 4'b0000);
            end else begin
                while (q[d].size() > 0 && q[d][0].due < cyc) begin
                    e = q[d].pop_front();
                    n_vec++;
                    n_err++;
                    $display("FAIL missed_result dut=%0d due=%0d: no output, expected flags %b", d, e.due, e.flags);
                end
                if (q[d].size() > 0 && q[d][0].due == cyc) begin
                    e = q[d].pop_front();
                    held[d] = e.flags;
                    check(d == 0 ? "w2_result" : "w4_result", act[d], {1'b1, e.flags});
                    n_vec++;
                    if ($countones(act[d][2:0]) != 1) begin
                        n_err++;
                        $display("FAIL onehot dut=%0d: got flags %b, required exactly one set", d, act[d][2:0]);
                    end
                end else begin
                    check(d == 0 ? "w2_idle_hold" : "w4_idle_hold", act[d], {1'b0, held[d]});
                end
            end
        end
    end

    initial begin
        b2.A = '0; b2.B = '0; b2.signed_mode = 1'b0; b2.in_valid = 1'b0;
        b4.A = '0; b4.B = '0; b4.signed_mode = 1'b0; b4.in_valid = 1'b0;
        held[0] = 3'b000;
        held[1] = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        check("reset_state_w2", act[0], 4'b0000);
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                d2(a, b, 1'b0, 1'b1);
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                d2(a, b, 1'b1, 1'b1);

        d2(2, 1, 1'b0, 1'b1);
        repeat (3) d2(int'($urandom), int'($urandom), 1'($urandom), 1'b0);

        d2(2, 1, 1'b0, 1'b1);
        d2(2, 1, 1'b1, 1'b1);

        d4(8, 7, 1'b0, 1'b1);
        d4(8, 7, 1'b1, 1'b1);
        d4(15, 15, 1'b0, 1'b1);
        d4(15, 15, 1'b1, 1'b1);

        repeat (300)
            drive(int'($urandom), int'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom), int'($urandom), 1'($urandom), 1'($urandom));

        // Reset lands between edges while a result is showing and another sample is still presented.
        d2(3, 0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        #1;
        check("async_clear_w2", {b2.out_valid, b2.A_gt_B, b2.A_eq_B, b2.A_lt_B}, 4'b0000);
        check("async_clear_w4", {b4.out_valid, b4.A_gt_B, b4.A_eq_B, b4.A_lt_B}, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_w2", {b2.out_valid, b2.A_gt_B, b2.A_eq_B, b2.A_lt_B}, 4'b0000);
        b2.in_valid = 1'b0;
        b4.in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        d2(1, 1, 1'b0, 1'b1);

        d2(0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (q[d].size() != 0) begin
                n_err++;
                $display("FAIL drain dut=%0d: %0d results still pending, required 0", d, q[d].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/comparator_2bit.md
# comparator_2bit

Registered magnitude comparator for two WIDTH-bit operands (default 2 bits). It produces mutually exclusive greater-than, equal and less-than flags, one clock cycle after a qualified input sample. Operands are unsigned by default, with a per-sample signed (two's complement) mode. It is a leaf datapath block feeding control logic that needs clean, registered, one-hot compare results.

## Interface
Parameters:
- WIDTH, 2, operand width in bits (legal range ≥1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion clears state immediately; deassertion is synchronised externally to clk.
- in_valid  input  1  qualifies A, B and signed_mode for the current cycle.
- signed_mode  input  1  0 = unsigned compare, 1 = two's-complement compare.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- A_gt_B  output  1  registered; A > B for the last accepted sample.
- A_eq_B  output  1  registered; A == B for the last accepted sample.
- A_lt_B  output  1  registered; A < B for the last accepted sample.
- out_valid  output  1  registered; high for exactly one cycle per accepted sample.

## Operation
- Sample acceptance:
  - A sample is accepted on any rising clk edge with in_valid=1 and rst_n=1.
  - No backpressure; every valid cycle is accepted.
- Compare:
  - Unsigned mode: A and B are treated as 0..2^WIDTH−1.
  - Signed mode: A and B are treated as −2^(WIDTH−1)..2^(WIDTH−1)−1.
  - The MSB is the sign bit only when signed_mode=1.
- Outputs after an accepted sample:
  - Exactly one of A_gt_B, A_eq_B, A_lt_B is 1 (one-hot).
  - The bench must check sum == 1 whenever out_valid=1.
- A_eq_B depends only on bitwise equality and is independent of signed_mode.
- Cycles with in_valid=0:
  - out_valid goes to 0 on the next edge.
  - The three flags hold their last values; they are not cleared.
- Reset state (all registers cleared):
  - A_gt_B=0, A_eq_B=0, A_lt_B=0, out_valid=0.
  - Flags are not one-hot in this state; consumers must qualify with out_valid.
- No X propagation requirement on A/B when in_valid=0; those inputs are don't-care.

## Timing
- Latency: 1 cycle. A sample accepted at edge N appears on the outputs after edge N, valid through edge N+1.
- Throughput: 1 sample per cycle. Back-to-back valid samples produce back-to-back out_valid pulses with updated flags.
- Asynchronous reset:
  - Outputs clear immediately on rst_n falling, without waiting for a clk edge.
  - Reset asserted mid-stream discards any in-flight sample; no out_valid is produced for it.
- First accept: the first sample after rst_n rises is taken on the first rising edge with in_valid=1.
- Outputs are driven directly from flops; no combinational path from inputs to outputs.
- signed_mode is sampled together with A/B; a change between samples affects only the next accepted sample.

## Test plan
- Exhaustive unsigned sweep, WIDTH=2, signed_mode=0:
  - Drive all 16 (A,B) pairs back-to-back with in_valid=1.
  - Each result appears one cycle later, e.g. A=11,B=01 → GT=1; A=10,B=10 → EQ=1; A=00,B=11 → LT=1.
  - Flags one-hot on every out_valid cycle.
- Signed sweep, signed_mode=1, all 16 pairs:
  - A=10 (−2), B=01 (+1) → LT=1.
  - A=01, B=11 (−1) → GT=1.
  - A=11, B=11 → EQ=1.
- Reset behaviour:
  - With rst_n=0, outputs are all 0.
  - Assert rst_n low asynchronously between edges after the sample A=11,B=00 is accepted → all outputs 0 immediately, no out_valid pulse follows.
  - Release reset, then send A=01,B=01 → EQ=1, out_valid=1 one cycle later.
- Hold on idle:
  - Send A=10,B=01 (GT=1), then drop in_valid for 3 cycles while changing A/B randomly.
  - out_valid is 0 on those cycles; GT stays 1, EQ and LT stay 0.
- Mode switch back-to-back:
  - A=10,B=01 with signed_mode=0 → GT.
  - Next cycle, same operands with signed_mode=1 → LT.
  - Both out_valid pulses occur on consecutive cycles.
- Parameter check, WIDTH=4:
  - Unsigned: A=1000, B=0111 → GT.
  - Signed: same operands → LT.
  - A=1111, B=1111 → EQ in both modes.
